// File: rtl/pmu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pmu_pkg
//  Description : Shared state encoding, op encoding and width helpers for the
//                PMU batch engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package pmu_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } pmu_state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Result width: one guard bit above the operand width.
    function automatic int pmu_out_w(input int data_w);
        return data_w + 1;
    endfunction

    // Lane index width; a single-lane build still needs a 1-bit index.
    function automatic int pmu_lane_w(input int num_lanes);
        return (num_lanes > 1) ? $clog2(num_lanes) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pmu_lane_alu.sv
`default_nettype none
// ============================================================================
//  Module      : pmu_lane_alu
//  Description : Combinational per-lane add/subtract with signed or unsigned
//                operand extension to a DATA_W+1 result.
//  Revision    : 1.0 - initial release
// ============================================================================
module pmu_lane_alu
    import pmu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              op_sub,
    input  logic              op_signed,
    output logic [DATA_W:0]   result
);

    logic [DATA_W:0] w_ext_a;
    logic [DATA_W:0] w_ext_b;

    // Extend both operands by one bit (sign or zero), then wrap modulo 2^OUT_W.
    always_comb begin
        w_ext_a = {op_signed & a[DATA_W-1], a};
        w_ext_b = {op_signed & b[DATA_W-1], b};
        result  = (op_sub == OP_ADD) ? (w_ext_a + w_ext_b) : (w_ext_a - w_ext_b);
    end

endmodule
`default_nettype wire

// File: rtl/pmu_batch_engine.sv
`default_nettype none
// ============================================================================
//  Module      : pmu_batch_engine
//  Description : Streams operand pairs into up to NUM_LANES lanes, computes
//                all loaded lanes in parallel on start, then drains results
//                over a valid/ready stream with index and last flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module pmu_batch_engine
    import pmu_pkg::*;
#(
    parameter int NUM_LANES   = 240,
    parameter int DATA_W      = 16,
    parameter int COMPUTE_LAT = 2,
    localparam int OUT_W      = pmu_out_w(DATA_W),
    localparam int LANE_W     = pmu_lane_w(NUM_LANES),
    localparam int CNT_W      = $clog2(NUM_LANES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              start,
    input  logic              op_sub,
    input  logic              op_signed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [LANE_W-1:0] out_idx,
    output logic              out_last,
    output logic [CNT_W-1:0]  lane_count,
    output logic              busy,
    output logic              err_empty
);

    localparam int LAT_W = (COMPUTE_LAT > 1) ? $clog2(COMPUTE_LAT) : 1;

    pmu_state_e        r_state;
    pmu_state_e        w_state_next;
    logic [CNT_W-1:0]  r_count;
    logic [LANE_W-1:0] r_rd_ptr;
    logic [LAT_W-1:0]  r_lat;
    logic              r_op_sub;
    logic              r_op_signed;
    logic              r_err_empty;

    logic [DATA_W-1:0] r_a   [NUM_LANES];
    logic [DATA_W-1:0] r_b   [NUM_LANES];
    logic [OUT_W-1:0]  r_res [NUM_LANES];
    logic [OUT_W-1:0]  w_alu_res [NUM_LANES];
    logic [OUT_W-1:0]  w_rd_data;

    logic w_in_ready;
    logic w_accept;
    logic w_start_ok;
    logic w_start_empty;
    logic w_lat_done;
    logic w_rd_last;
    logic w_xfer;

    // Handshake and event decode; the empty check sees a same-cycle accept.
    always_comb begin
        w_in_ready    = (r_state == ST_LOAD) && (r_count < CNT_W'(NUM_LANES));
        w_accept      = in_valid && w_in_ready;
        w_start_ok    = start && (r_state == ST_LOAD) && ((r_count != '0) || w_accept);
        w_start_empty = start && (r_state == ST_LOAD) && (r_count == '0) && !w_accept;
        w_lat_done    = (r_state == ST_COMPUTE) && (r_lat == '0);
        w_rd_last     = (CNT_W'(r_rd_ptr) == (r_count - CNT_W'(1)));
        w_xfer        = (r_state == ST_DRAIN) && out_ready;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD:    if (w_start_ok)           w_state_next = ST_COMPUTE;
            ST_COMPUTE: if (r_lat == '0)          w_state_next = ST_DRAIN;
            ST_DRAIN:   if (out_ready && w_rd_last) w_state_next = ST_LOAD;
            default:                              w_state_next = ST_LOAD;
        endcase
    end

    // Outputs; result data is gated so nothing stale is visible outside DRAIN.
    always_comb begin
        in_ready   = w_in_ready;
        out_valid  = (r_state == ST_DRAIN);
        busy       = (r_state != ST_LOAD);
        out_last   = (r_state == ST_DRAIN) && w_rd_last;
        out_data   = (r_state == ST_DRAIN) ? w_rd_data : '0;
        out_idx    = r_rd_ptr;
        lane_count = r_count;
        err_empty  = r_err_empty;
    end

    // Lane count, latency counter, read pointer, op latches and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_lat       <= '0;
            r_rd_ptr    <= '0;
            r_op_sub    <= 1'b0;
            r_op_signed <= 1'b0;
            r_err_empty <= 1'b0;
        end else begin
            r_err_empty <= w_start_empty;
            if (w_accept) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_xfer && w_rd_last) begin
                r_count <= '0;
            end
            if (w_start_ok) begin
                r_lat       <= LAT_W'(COMPUTE_LAT - 1);
                r_op_sub    <= op_sub;
                r_op_signed <= op_signed;
            end else if ((r_state == ST_COMPUTE) && (r_lat != '0)) begin
                r_lat <= r_lat - LAT_W'(1);
            end
            if (w_xfer) begin
                r_rd_ptr <= w_rd_last ? '0 : (r_rd_ptr + LANE_W'(1));
            end
        end
    end

    // Operand and result stores; contents need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_accept && (r_count == CNT_W'(i))) begin
                r_a[i] <= in_a;
                r_b[i] <= in_b;
            end
            if (w_lat_done && (CNT_W'(i) < r_count)) begin
                r_res[i] <= w_alu_res[i];
            end
        end
    end

    // Result read mux addressed by the read pointer.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (r_rd_ptr == LANE_W'(i)) begin
                w_rd_data = r_res[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        pmu_lane_alu #(
            .DATA_W (DATA_W)
        ) u_alu (
            .a         (r_a[g]),
            .b         (r_b[g]),
            .op_sub    (r_op_sub),
            .op_signed (r_op_signed),
            .result    (w_alu_res[g])
        );
    end

endmodule
`default_nettype wire
